// File: rtl/alu_instr_decoder_register_file.sv
// Single-cycle decode/execute slice: instruction decoder, 16x32 register
// file with r0 hard-wired to zero, and a combinational ALU. The result is
// written back to rA at the clock edge where wr_commit is high.
module alu_instr_decoder_register_file #(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] instr,
    input  logic              exec_en,
    input  logic [3:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data,
    output logic [DATA_W-1:0] alu_result,
    output logic              illegal,
    output logic [3:0]        wr_sel,
    output logic              wr_commit
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SLTU = 4'd2,
        OP_SLTS = 4'd3,
        OP_AND  = 4'd4,
        OP_ORR  = 4'd5,
        OP_XOR  = 4'd6,
        OP_NOR  = 4'd7,
        OP_LSL  = 4'd8,
        OP_LSR  = 4'd9,
        OP_ASR  = 4'd10
    } opcode_t;

    logic [DATA_W-1:0] regs [NUM_REGS];

    logic [3:0]        group;
    logic [3:0]        ra;
    logic [3:0]        rb;
    logic [3:0]        rc;
    logic [3:0]        opcode;
    logic [15:0]       imm16;
    logic              sign_ext;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [4:0]        shamt;

    // Field extraction; the opcode lives in different bits per group.
    always_comb begin
        group  = instr[31:28];
        ra     = instr[27:24];
        rb     = instr[23:20];
        rc     = instr[19:16];
        imm16  = instr[15:0];
        opcode = (group == 4'd0) ? instr[3:0] : instr[19:16];
    end

    // Immediate extension: signed only for the arithmetic/signed-compare ops.
    always_comb begin
        sign_ext = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_SLTS);
        imm_ext  = sign_ext ? {{(DATA_W-16){imm16[15]}}, imm16}
                            : {{(DATA_W-16){1'b0}}, imm16};
    end

    // Operand fetch: r0 always reads zero, reads see pre-edge contents.
    always_comb begin
        op_a  = (rb == 4'd0) ? '0 : regs[rb];
        op_b  = (group == 4'd0) ? ((rc == 4'd0) ? '0 : regs[rc]) : imm_ext;
        shamt = op_b[4:0];
    end

    // ALU and legality check; illegal encodings force a zero result.
    always_comb begin
        illegal    = 1'b0;
        alu_result = '0;
        if (group > 4'd1) begin
            illegal = 1'b1;
        end else begin
            case (opcode)
                OP_ADD:  alu_result = op_a + op_b;
                OP_SUB:  alu_result = op_a - op_b;
                OP_SLTU: alu_result = {{(DATA_W-1){1'b0}}, (op_a < op_b)};
                OP_SLTS: alu_result = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
                OP_AND:  alu_result = op_a & op_b;
                OP_ORR:  alu_result = op_a | op_b;
                OP_XOR:  alu_result = op_a ^ op_b;
                OP_NOR:  alu_result = ~(op_a | op_b);
                OP_LSL:  alu_result = op_a << shamt;
                OP_LSR:  alu_result = op_a >> shamt;
                OP_ASR:  alu_result = DATA_W'($signed(op_a) >>> shamt);
                default: illegal    = 1'b1;
            endcase
        end
    end

    // Write-back qualification and debug read port (forced to zero in reset).
    always_comb begin
        wr_sel    = ra;
        wr_commit = exec_en && !illegal && (ra != 4'd0);
        dbg_data  = (rst || dbg_sel == 4'd0) ? '0 : regs[dbg_sel];
    end

    // Register file: asynchronous clear, single write port; r0 is never written
    // because wr_commit excludes rA == 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_commit) begin
            regs[ra] <= alu_result;
        end
    end

endmodule

// File: tb/tb_alu_instr_decoder_register_file.sv
// Directed testbench for alu_instr_decoder_register_file using immediate
// assertions; expected values are hand-computed constants.
module tb_alu_instr_decoder_register_file;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        exec_en;
    logic [3:0]  dbg_sel;
    logic [31:0] dbg_data;
    logic [31:0] alu_result;
    logic        illegal;
    logic [3:0]  wr_sel;
    logic        wr_commit;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_regs [16];

    alu_instr_decoder_register_file #(.NUM_REGS(16), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .exec_en    (exec_en),
        .dbg_sel    (dbg_sel),
        .dbg_data   (dbg_data),
        .alu_result (alu_result),
        .illegal    (illegal),
        .wr_sel     (wr_sel),
        .wr_commit  (wr_commit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] g0(input logic [3:0] op, input logic [3:0] a,
                                       input logic [3:0] b, input logic [3:0] c);
        return {4'd0, a, b, c, 12'd0, op};
    endfunction

    function automatic logic [31:0] g1(input logic [3:0] op, input logic [3:0] a,
                                       input logic [3:0] b, input logic [15:0] imm);
        return {4'd1, a, b, op, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Apply one instruction, check combinational outputs, then clock it.
    task automatic run(input string tag, input logic [31:0] ins, input logic en,
                       input logic [31:0] exp_alu, input logic exp_ill, input logic exp_com);
        instr   = ins;
        exec_en = en;
        #1;
        chk({tag, ".alu"}, alu_result, exp_alu);
        chk({tag, ".illegal"}, {31'd0, illegal}, {31'd0, exp_ill});
        chk({tag, ".commit"}, {31'd0, wr_commit}, {31'd0, exp_com});
        $display("txn %s instr=%h alu=%h illegal=%0b commit=%0b", tag, ins, alu_result, illegal, wr_commit);
        @(posedge clk);
        #1;
        if (exp_com) exp_regs[ins[27:24]] = exp_alu;
        exec_en = 1'b0;
    endtask

    task automatic check_reg(input string tag, input logic [3:0] sel, input logic [31:0] expv);
        dbg_sel = sel;
        #1;
        chk(tag, dbg_data, expv);
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 16; i++) begin
            dbg_sel = 4'(i);
            #1;
            chk($sformatf("%s.r%0d", tag, i), dbg_data, exp_regs[i]);
        end
    endtask

    initial begin
        rst     = 1'b1;
        instr   = 32'd0;
        exec_en = 1'b0;
        dbg_sel = 4'd0;
        for (int i = 0; i < 16; i++) exp_regs[i] = 32'd0;

        // During reset: operands read as zero; a commit-eligible edge writes nothing.
        #2;
        instr = g0(4'd0, 4'd1, 4'd2, 4'd3);
        #1;
        chk("rst.alu_add_regs", alu_result, 32'd0);
        instr   = g1(4'd0, 4'd1, 4'd0, 16'd5);
        exec_en = 1'b1;
        #1;
        chk("rst.alu_add_imm", alu_result, 32'd5);
        @(posedge clk);
        #1;
        exec_en = 1'b0;
        rst     = 1'b0;
        @(posedge clk);
        #1;
        check_all("reset");

        run("add_r1_7fff", g1(4'd0, 4'd1, 4'd0, 16'h7FFF), 1'b1, 32'h0000_7FFF, 1'b0, 1'b1);
        run("add_r2_ffff", g1(4'd0, 4'd2, 4'd0, 16'hFFFF), 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
        run("add_r3_r1_r2", g0(4'd0, 4'd3, 4'd1, 4'd2), 1'b1, 32'h0000_7FFE, 1'b0, 1'b1);
        chk("wr_sel_r3", {28'd0, wr_sel}, 32'd3);
        run("sltu_r4", g0(4'd2, 4'd4, 4'd2, 4'd1), 1'b1, 32'd0, 1'b0, 1'b1);
        run("slts_r5", g0(4'd3, 4'd5, 4'd2, 4'd1), 1'b1, 32'd1, 1'b0, 1'b1);
        run("orr_r6_ffff", g1(4'd5, 4'd6, 4'd0, 16'hFFFF), 1'b1, 32'h0000_FFFF, 1'b0, 1'b1);
        run("add_r7_36", g1(4'd0, 4'd7, 4'd0, 16'd36), 1'b1, 32'd36, 1'b0, 1'b1);
        run("lsr_r8", g0(4'd9, 4'd8, 4'd2, 4'd7), 1'b1, 32'h0FFF_FFFF, 1'b0, 1'b1);
        run("asr_r9", g0(4'd10, 4'd9, 4'd2, 4'd7), 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
        run("lsl_r10", g0(4'd8, 4'd10, 4'd1, 4'd7), 1'b1, 32'h0007_FFF0, 1'b0, 1'b1);
        run("sub_r12_imm1", g1(4'd1, 4'd12, 4'd0, 16'd1), 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
        run("nor_r13", g0(4'd7, 4'd13, 4'd0, 4'd0), 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
        run("xor_r14", g0(4'd6, 4'd14, 4'd1, 4'd6), 1'b1, 32'h0000_8000, 1'b0, 1'b1);
        run("and_r15", g1(4'd4, 4'd15, 4'd2, 16'h8001), 1'b1, 32'h0000_8001, 1'b0, 1'b1);
        // Back-to-back dependency on r11.
        run("inc_r11_a", g1(4'd0, 4'd11, 4'd11, 16'd1), 1'b1, 32'd1, 1'b0, 1'b1);
        run("inc_r11_b", g1(4'd0, 4'd11, 4'd11, 16'd1), 1'b1, 32'd2, 1'b0, 1'b1);
        check_all("after_ops");

        // Discarded and illegal writes.
        run("write_r0", g0(4'd0, 4'd0, 4'd1, 4'd1), 1'b1, 32'h0000_FFFE, 1'b0, 1'b0);
        run("g0_op12", g0(4'd12, 4'd14, 4'd1, 4'd1), 1'b1, 32'd0, 1'b1, 1'b0);
        run("group5", {4'd5, 4'd14, 4'd1, 4'd1, 16'd0}, 1'b1, 32'd0, 1'b1, 1'b0);
        run("en_low_add", g0(4'd0, 4'd15, 4'd1, 4'd1), 1'b0, 32'h0000_FFFE, 1'b0, 1'b0);
        check_all("no_write");

        // Mid-run reset: clears without a clock edge, blocks writes while high.
        dbg_sel = 4'd1;
        #1;
        chk("pre_rst_r1", dbg_data, 32'h0000_7FFF);
        rst = 1'b1;
        #1;
        chk("async_rst_r1", dbg_data, 32'd0);
        instr   = g1(4'd0, 4'd1, 4'd0, 16'd5);
        exec_en = 1'b1;
        @(posedge clk);
        #1;
        exec_en = 1'b0;
        for (int i = 0; i < 16; i++) exp_regs[i] = 32'd0;
        rst = 1'b0;
        #1;
        check_all("post_rst");
        run("first_after_rst", g1(4'd0, 4'd1, 4'd0, 16'd5), 1'b1, 32'd5, 1'b0, 1'b1);
        check_reg("r1_after_rst", 4'd1, 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
